mux2: RTL and testbench

MUX2 -- requirements
Module: mux2

---
 rtl/mux2_pkg.sv | 20 ++
 rtl/mux2_sel_stats.sv | 48 ++++
 rtl/mux2.sv | 75 +++++++
 tb/tb_mux2.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mux2_pkg.sv
// -----------------------------------------------------------------------------
// mux2_pkg
// Shared constants, the default data type and a small helper for the mux2 block.
//   MUX2_WIDTH_DEF : default data width of mux2
//   MUX2_CNT_W_DEF : default width of the select-switch counter
//   mux2_data_t    : data word at the default width
//   sel_changed()  : true when the current select differs from its registered copy
// -----------------------------------------------------------------------------
package mux2_pkg;

  localparam int MUX2_WIDTH_DEF = 4;
  localparam int MUX2_CNT_W_DEF = 8;

  typedef logic [MUX2_WIDTH_DEF-1:0] mux2_data_t;

  function automatic logic sel_changed(input logic sel, input logic sel_q);
    return sel ^ sel_q;
  endfunction

endpackage

// File: rtl/mux2_sel_stats.sv
// -----------------------------------------------------------------------------
// mux2_sel_stats
// Select-switch statistics for mux2: keeps a registered copy of the select
// and counts the rising clock edges at which the select differs from it.
// The counter wraps silently at 2^CNT_W.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset (clears s_q and the counter)
//   i_s      : select being watched
//   o_s_q    : registered copy of i_s
//   o_sw_cnt : number of select transitions seen, modulo 2^CNT_W
// -----------------------------------------------------------------------------
module mux2_sel_stats
  import mux2_pkg::*;
#(
  parameter int CNT_W = MUX2_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_s,
  output logic             o_s_q,
  output logic [CNT_W-1:0] o_sw_cnt
);

  logic             r_s_q;
  logic [CNT_W-1:0] r_cnt;
  logic             w_changed;

  // r_s_q clears to 0 in reset, so a select of 1 at the first edge after
  // release is counted as a transition.
  assign w_changed = sel_changed(i_s, r_s_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s_q <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s_q <= i_s;
      if (w_changed) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_s_q    = r_s_q;
  assign o_sw_cnt = r_cnt;

endmodule

// File: rtl/mux2.sv
// -----------------------------------------------------------------------------
// mux2
// Two-input multiplexer with a combinational output and a registered copy.
// Optional select-switch statistics are built when MUX2_SEL_STATS_EN is
// defined; without it the statistics logic and the sw_cnt port are absent.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset (clears y_q and statistics)
//   a1     : data input chosen when s = 0
//   a2     : data input chosen when s = 1
//   s      : select
//   y      : combinational mux output, valid during reset
//   y_q    : y registered on every rising edge
//   sw_cnt : select transition count (MUX2_SEL_STATS_EN only)
// -----------------------------------------------------------------------------
module mux2
  import mux2_pkg::*;
#(
  parameter int WIDTH = MUX2_WIDTH_DEF,
  parameter int CNT_W = MUX2_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic             s,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q
`ifdef MUX2_SEL_STATS_EN
  ,
  output logic [CNT_W-1:0] sw_cnt
`endif
);

  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] r_y_q;

  // Catch a nonsensical counter width at elaboration in every build.
  if (CNT_W < 1) begin : g_cnt_w_invalid
    $error("mux2: CNT_W must be at least 1");
  end

  // Pure combinational select; no dependence on clk or rst.
  assign w_y = s ? a2 : a1;
  assign y   = w_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y_q <= '0;
    end else begin
      r_y_q <= w_y;
    end
  end

  assign y_q = r_y_q;

`ifdef MUX2_SEL_STATS_EN
  logic w_s_q;

  mux2_sel_stats #(
    .CNT_W (CNT_W)
  ) u_sel_stats (
    .clk      (clk),
    .rst      (rst),
    .i_s      (s),
    .o_s_q    (w_s_q),
    .o_sw_cnt (sw_cnt)
  );

  // s_q is kept for probing; nothing in the top consumes it.
  logic w_s_q_unused;
  assign w_s_q_unused = w_s_q;
`endif

endmodule

// File: tb/tb_mux2.sv
// -----------------------------------------------------------------------------
// tb_mux2
// Directed and randomized checks of mux2 against a behavioural model.
// Select-statistics checks are compiled only with MUX2_SEL_STATS_EN.
// -----------------------------------------------------------------------------
module tb_mux2;

  localparam int W  = 4;
  localparam int CW = 8;

  logic          clk;
  logic          rst;
  logic [W-1:0]  a1;
  logic [W-1:0]  a2;
  logic          s;
  logic [W-1:0]  y;
  logic [W-1:0]  y_q;
`ifdef MUX2_SEL_STATS_EN
  logic [CW-1:0] sw_cnt;
`endif

  int n_cmp;
  int n_err;

  // Behavioural model state
  logic [W-1:0] m_yq;
  logic         m_sq;
  int           m_cnt;

  mux2 #(
    .WIDTH (W),
    .CNT_W (CW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .a1     (a1),
    .a2     (a2),
    .s      (s),
    .y      (y),
    .y_q    (y_q)
`ifdef MUX2_SEL_STATS_EN
    ,
    .sw_cnt (sw_cnt)
`endif
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model ----------------
  function automatic logic [W-1:0] sel_model(input logic [W-1:0] d0,
                                             input logic [W-1:0] d1,
                                             input logic         sel);
    logic [W-1:0] opts [2];
    opts[0] = d0;
    opts[1] = d1;
    return opts[int'(sel)];
  endfunction

  function automatic logic [CW-1:0] cnt_model();
    return CW'(m_cnt % (1 << CW));
  endfunction

  task automatic model_reset();
    m_yq  = '0;
    m_sq  = 1'b0;
    m_cnt = 0;
  endtask

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
`ifdef MUX2_SEL_STATS_EN
    chk(tag, 32'(sw_cnt), 32'(cnt_model()));
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // ---------------- driver ----------------
  // One rising edge; model captures the inputs present at that edge,
  // then sampling resumes 1 time unit later.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (s !== m_sq) m_cnt++;
      m_sq = s;
      m_yq = sel_model(a1, a2, s);
    end
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    model_reset();
    rst = 1'b1;
    a1  = '0;
    a2  = '0;
    s   = 1'b0;

    // Reset held with clock running
    a1 = 4'b0101;
    step();
    step();
    chk("rst_yq", 32'(y_q), 32'h0);
    chk_cnt("rst_cnt");
    chk("rst_y_comb", 32'(y), 32'h5);

    // Release, one edge loads y
    rst = 1'b0;
    step();
    chk("rel_yq", 32'(y_q), 32'h5);
    chk("rel_yq_model", 32'(y_q), 32'(m_yq));

    // Select swing without an edge
    a1 = 4'b1111;
    a2 = 4'b0000;
    s  = 1'b0;
    #1 chk("sel0_y", 32'(y), 32'hF);
    s  = 1'b1;
    #1 chk("sel1_y", 32'(y), 32'h0);

    // Equal inputs make select irrelevant
    a1 = 4'b1010;
    a2 = 4'b1010;
    s  = 1'b0;
    #1 chk("eq_s0", 32'(y), 32'hA);
    s  = 1'b1;
    #1 chk("eq_s1", 32'(y), 32'hA);
    s  = 1'b0;
    #1 chk("eq_s0b", 32'(y), 32'hA);
    step();
    chk("eq_yq", 32'(y_q), 32'hA);
    chk_cnt("eq_cnt");

    // Asynchronous reset between edges
    a1 = 4'b1111;
    s  = 1'b0;
    step();
    chk("pre_async_yq", 32'(y_q), 32'hF);
    #2 rst = 1'b1;
    model_reset();
    #1 chk("async_yq", 32'(y_q), 32'h0);
    chk_cnt("async_cnt");
    chk("async_y_comb", 32'(y), 32'hF);
    step();
    rst = 1'b0;
    a1  = 4'b0011;
    a2  = 4'b0000;
    s   = 1'b0;
    step();
    chk("resume_yq", 32'(y_q), 32'h3);

    // Select and data change together
    s  = 1'b1;
    a2 = 4'b0110;
    #1 chk("same_cyc_y", 32'(y), 32'h6);
    step();
    chk("same_cyc_yq", 32'(y_q), 32'h6);
    chk_cnt("same_cyc_cnt");

    // Randomized traffic with occasional resets
    for (int i = 0; i < 300; i++) begin
      a1 = W'($urandom_range(0, (1 << W) - 1));
      a2 = W'($urandom_range(0, (1 << W) - 1));
      s  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        model_reset();
      end else begin
        rst = 1'b0;
      end
      #1;
      chk("rnd_y", 32'(y), 32'(sel_model(a1, a2, s)));
      if (rst) chk("rnd_async_yq", 32'(y_q), 32'h0);
      step();
      chk("rnd_yq", 32'(y_q), 32'(m_yq));
      chk_cnt("rnd_cnt");
    end

`ifdef MUX2_SEL_STATS_EN
    // Counter wrap: 256 toggles from reset, then 3 more
    rst = 1'b1;
    s   = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      s = ~s;
      step();
    end
    chk("wrap_cnt", 32'(sw_cnt), 32'h0);
    chk("wrap_cnt_model", 32'(sw_cnt), 32'(cnt_model()));
    for (int i = 0; i < 3; i++) begin
      s = ~s;
      step();
    end
    chk("wrap_plus3", 32'(sw_cnt), 32'h3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
